// File: rtl/csr_regfile.sv
// csr_regfile: LoongArch architectural CSR file. Masked CSR writes,
// exception/ertn updates from WB, combinational reads, and the
// stable-counter timer that sets the timer-interrupt pending bit.
`timescale 1ns/1ps

module csr_regfile (
    input  logic        clk,
    input  logic        resetn,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [13:0] csr_wr_num,
    input  logic [31:0] csr_wr_mask,
    input  logic [31:0] csr_wr_value,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_pc,
    output logic        has_int
);

    localparam logic [13:0] ADDR_CRMD   = 14'h0;
    localparam logic [13:0] ADDR_PRMD   = 14'h1;
    localparam logic [13:0] ADDR_ECFG   = 14'h4;
    localparam logic [13:0] ADDR_ESTAT  = 14'h5;
    localparam logic [13:0] ADDR_ERA    = 14'h6;
    localparam logic [13:0] ADDR_EENTRY = 14'hC;
    localparam logic [13:0] ADDR_SAVE0  = 14'h30;
    localparam logic [13:0] ADDR_TID    = 14'h40;
    localparam logic [13:0] ADDR_TCFG   = 14'h41;
    localparam logic [13:0] ADDR_TVAL   = 14'h42;

    localparam logic [13:0] ADDR_TICLR  = 14'h44;

    // Bit-enabled write limited to the register's writable bits.
    function automatic logic [31:0] mwrite(input logic [31:0] old_v,
                                           input logic [31:0] val,
                                           input logic [31:0] mask,
                                           input logic [31:0] wmask);
        return (old_v & ~(mask & wmask)) | (val & mask & wmask);
    endfunction

    // Only the writable fields are stored; fixed/zero bits are rebuilt on read.
    logic [2:0]  crmd_q, crmd_d;          // {IE, PLV}
    logic [2:0]  prmd_q, prmd_d;          // {PIE, PPLV}
    logic [12:0] ecfg_q, ecfg_d;          // LIE
    logic [12:0] estat_is_q, estat_is_d;  // IS
    logic [5:0]  ecode_q, ecode_d;
    logic [8:0]  esub_q, esub_d;
    logic [31:0] era_q, era_d;
    logic [25:0] eentry_q, eentry_d;      // VA[31:6]
    logic [31:0] save_q [4];
    logic [31:0] save_d [4];
    logic [31:0] tid_q, tid_d;
    logic [31:0] tcfg_q, tcfg_d;
    logic [31:0] tval_q, tval_d;

    logic [31:0] crmd_rd, prmd_rd, ecfg_rd, estat_rd, eentry_rd;
    logic [31:0] wtmp;
    logic        wr_tcfg;
    logic        timer_set;
    logic        ticlr_clr;

    assign crmd_rd   = {28'b0, 1'b1, crmd_q};
    assign prmd_rd   = {29'b0, prmd_q};
    assign ecfg_rd   = {19'b0, ecfg_q};
    assign estat_rd  = {1'b0, esub_q, ecode_q, 3'b0, estat_is_q};
    assign eentry_rd = {eentry_q, 6'b0};

    assign wr_tcfg   = csr_we && (csr_wr_num == ADDR_TCFG);

    assign ex_entry  = eentry_rd;
    assign ertn_pc   = era_q;
    assign has_int   = crmd_q[2] & (|(estat_is_q & ecfg_q));

    // Next-state: software writes, then ertn, then exception (later assignments win).
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        crmd_d     = crmd_q;
        prmd_d     = prmd_q;
        ecfg_d     = ecfg_q;
        estat_is_d = estat_is_q;
        ecode_d    = ecode_q;
        esub_d     = esub_q;
        era_d      = era_q;
        eentry_d   = eentry_q;
        tid_d      = tid_q;
        tcfg_d     = tcfg_q;
        tval_d     = tval_q;
        wtmp       = 32'b0;
        timer_set  = 1'b0;
        ticlr_clr  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            save_d[i] = save_q[i];
        end

        if (csr_we) begin
            case (csr_wr_num)
                ADDR_CRMD: begin
                    wtmp   = mwrite(crmd_rd, csr_wr_value, csr_wr_mask, 32'h0000_0007);
                    crmd_d = wtmp[2:0];
                end
                ADDR_PRMD: begin
                    wtmp   = mwrite(prmd_rd, csr_wr_value, csr_wr_mask, 32'h0000_0007);
                    prmd_d = wtmp[2:0];
                end
                ADDR_ECFG: begin
                    wtmp   = mwrite(ecfg_rd, csr_wr_value, csr_wr_mask, 32'h0000_1BFF);
                    ecfg_d = wtmp[12:0];
                end
                ADDR_ESTAT: begin
                    wtmp            = mwrite(estat_rd, csr_wr_value, csr_wr_mask, 32'h0000_0003);
                    estat_is_d[1:0] = wtmp[1:0];
                end
                ADDR_ERA:    era_d  = mwrite(era_q, csr_wr_value, csr_wr_mask, 32'hFFFF_FFFF);
                ADDR_EENTRY: begin
                    wtmp     = mwrite(eentry_rd, csr_wr_value, csr_wr_mask, 32'hFFFF_FFC0);
                    eentry_d = wtmp[31:6];
                end
                ADDR_TID:    tid_d  = mwrite(tid_q, csr_wr_value, csr_wr_mask, 32'hFFFF_FFFF);
                ADDR_TCFG:   tcfg_d = mwrite(tcfg_q, csr_wr_value, csr_wr_mask, 32'hFFFF_FFFF);
                ADDR_TICLR:  ticlr_clr = csr_wr_mask[0] & csr_wr_value[0];
                default: ;
            endcase
            for (int i = 0; i < 4; i++) begin
                if (csr_wr_num == ADDR_SAVE0 + 14'(i)) begin
                    save_d[i] = mwrite(save_q[i], csr_wr_value, csr_wr_mask, 32'hFFFF_FFFF);
                end
            end
        end

        if (ertn_flush) begin
            crmd_d = prmd_q;
        end

        if (wb_ex) begin
            prmd_d  = crmd_q;
            crmd_d  = 3'b000;
            era_d   = wb_pc;
            ecode_d = wb_ecode;
            esub_d  = wb_esubcode;
        end

        // Timer: reload on enabling write, expire at zero, else count down.
        if (wr_tcfg && tcfg_d[0]) begin
            tval_d = {tcfg_d[31:2], 2'b00};
        end else if (tcfg_d[0] && (tval_q == 32'h0)) begin
            timer_set = 1'b1;
            tval_d    = tcfg_d[1] ? {tcfg_d[31:2], 2'b00} : 32'hFFFF_FFFF;
        end else if (tcfg_d[0] && (tval_q != 32'hFFFF_FFFF)) begin
            tval_d = tval_q - 32'd1;
        end

        // Interrupt lines are sampled every cycle; timer set beats TICLR clear.
        estat_is_d[9:2] = hw_int_in;
        estat_is_d[10]  = 1'b0;
        estat_is_d[12]  = ipi_int_in;
        if (timer_set) begin
            estat_is_d[11] = 1'b1;
        end else if (ticlr_clr) begin
            estat_is_d[11] = 1'b0;
        end
    end

    // Combinational read port.
    always_comb begin
        csr_rvalue = 32'b0;
        case (csr_num)
            ADDR_CRMD:       csr_rvalue = crmd_rd;
            ADDR_PRMD:       csr_rvalue = prmd_rd;
            ADDR_ECFG:       csr_rvalue = ecfg_rd;
            ADDR_ESTAT:      csr_rvalue = estat_rd;
            ADDR_ERA:        csr_rvalue = era_q;
            ADDR_EENTRY:     csr_rvalue = eentry_rd;
            ADDR_SAVE0:      csr_rvalue = save_q[0];
            ADDR_SAVE0 + 1:  csr_rvalue = save_q[1];
            ADDR_SAVE0 + 2:  csr_rvalue = save_q[2];
            ADDR_SAVE0 + 3:  csr_rvalue = save_q[3];
            ADDR_TID:        csr_rvalue = tid_q;
            ADDR_TCFG:       csr_rvalue = tcfg_q;
            ADDR_TVAL:       csr_rvalue = tval_q;
            default:         csr_rvalue = 32'b0;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!resetn) begin
            crmd_q     <= 3'b000;
            prmd_q     <= 3'b000;
            ecfg_q     <= 13'b0;
            estat_is_q <= 13'b0;
            ecode_q    <= 6'b0;
            esub_q     <= 9'b0;
            era_q      <= 32'b0;
            eentry_q   <= 26'b0;
            tid_q      <= 32'b0;
            tcfg_q     <= 32'b0;
            tval_q     <= 32'hFFFF_FFFF;
            for (int i = 0; i < 4; i++) begin
                save_q[i] <= 32'b0;
            end
        end else begin
            crmd_q     <= crmd_d;
            prmd_q     <= prmd_d;
            ecfg_q     <= ecfg_d;
            estat_is_q <= estat_is_d;
            ecode_q    <= ecode_d;
            esub_q     <= esub_d;
            era_q      <= era_d;
            eentry_q   <= eentry_d;
            tid_q      <= tid_d;
            tcfg_q     <= tcfg_d;
            tval_q     <= tval_d;
            for (int i = 0; i < 4; i++) begin
                save_q[i] <= save_d[i];
            end
        end
    end

endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: scoreboard bench for csr_regfile. Expected values are
// queued as stimulus is applied and compared when the outputs are sampled.
`timescale 1ns/1ps

module tb_csr_regfile;

    logic        clk = 1'b0;
    logic        resetn;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [13:0] csr_wr_num;
    logic [31:0] csr_wr_mask;
    logic [31:0] csr_wr_value;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_pc;
    logic        has_int;

    localparam logic [13:0] A_CRMD = 14'h0, A_PRMD = 14'h1, A_ECFG = 14'h4, A_ESTAT = 14'h5,
                            A_ERA = 14'h6, A_EENTRY = 14'hC, A_SAVE1 = 14'h31, A_SAVE2 = 14'h32,
                            A_TCFG = 14'h41, A_TVAL = 14'h42, A_TICLR = 14'h44, A_NONE = 14'h7;

    typedef enum logic [1:0] {SEL_CSR, SEL_HAS_INT, SEL_EX_ENTRY, SEL_ERTN_PC} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [13:0] addr;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #50 clk = ~clk;

    csr_regfile dut (
        .clk          (clk),
        .resetn       (resetn),
        .csr_num      (csr_num),
        .csr_rvalue   (csr_rvalue),
        .csr_we       (csr_we),
        .csr_wr_num   (csr_wr_num),
        .csr_wr_mask  (csr_wr_mask),
        .csr_wr_value (csr_wr_value),
        .wb_ex        (wb_ex),
        .wb_ecode     (wb_ecode),
        .wb_esubcode  (wb_esubcode),
        .wb_pc        (wb_pc),
        .ertn_flush   (ertn_flush),
        .hw_int_in    (hw_int_in),
        .ipi_int_in   (ipi_int_in),
        .ex_entry     (ex_entry),
        .ertn_pc      (ertn_pc),
        .has_int      (has_int)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic exp_csr(input string tag, input logic [13:0] addr, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.sel = SEL_CSR; e.addr = addr; e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic exp_out(input string tag, input sel_e sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.addr = A_NONE; e.exp = exp;
        exp_q.push_back(e);
    endtask

    // Pop every pending expectation and compare against the DUT outputs.
    task automatic drain();
        exp_t        e;
        logic [31:0] got;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr_num = e.addr;
            #1;
            case (e.sel)
                SEL_CSR:      got = csr_rvalue;
                SEL_HAS_INT:  got = {31'b0, has_int};
                SEL_EX_ENTRY: got = ex_entry;
                default:      got = ertn_pc;
            endcase
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
        csr_we = 1'b1; csr_wr_num = num; csr_wr_mask = mask; csr_wr_value = val;
        tick();
        csr_we = 1'b0; csr_wr_mask = 32'b0; csr_wr_value = 32'b0;
    endtask

    task automatic pulse_ex(input logic [5:0] ecode, input logic [8:0] esub, input logic [31:0] pc);
        wb_ex = 1'b1; wb_ecode = ecode; wb_esubcode = esub; wb_pc = pc;
    endtask

    initial begin
        resetn = 1'b0; csr_num = 14'h0; csr_we = 1'b0; csr_wr_num = 14'h0;
        csr_wr_mask = 32'b0; csr_wr_value = 32'b0; wb_ex = 1'b0; wb_ecode = 6'b0;
        wb_esubcode = 9'b0; wb_pc = 32'b0; ertn_flush = 1'b0; hw_int_in = 8'b0; ipi_int_in = 1'b0;
        tick(); tick();
        resetn = 1'b1;

        // Reset state
        exp_csr("rst_crmd", A_CRMD, 32'h8);
        exp_csr("rst_prmd", A_PRMD, 32'h0);
        exp_csr("rst_estat", A_ESTAT, 32'h0);
        exp_csr("rst_era", A_ERA, 32'h0);
        exp_csr("rst_tcfg", A_TCFG, 32'h0);
        exp_csr("rst_tval", A_TVAL, 32'hFFFF_FFFF);
        exp_csr("rst_ticlr", A_TICLR, 32'h0);
        exp_out("rst_has_int", SEL_HAS_INT, 32'h0);
        exp_out("rst_ex_entry", SEL_EX_ENTRY, 32'h0);
        exp_out("rst_ertn_pc", SEL_ERTN_PC, 32'h0);
        drain();

        // Masked CRMD write, old value visible during the write cycle
        csr_we = 1'b1; csr_wr_num = A_CRMD; csr_wr_mask = 32'h4; csr_wr_value = 32'hFFFF_FFFF;
        exp_csr("crmd_no_bypass", A_CRMD, 32'h8);
        drain();
        tick();
        csr_we = 1'b0;
        exp_csr("crmd_masked", A_CRMD, 32'hC);
        drain();

        csr_write(A_EENTRY, 32'hFFFF_FFFF, 32'h1234_567F);
        exp_csr("eentry_rd", A_EENTRY, 32'h1234_5640);
        exp_out("ex_entry", SEL_EX_ENTRY, 32'h1234_5640);
        drain();

        csr_write(A_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exp_csr("ecfg_wmask", A_ECFG, 32'h0000_1BFF);
        exp_out("has_int_none", SEL_HAS_INT, 32'h0);
        drain();
        csr_write(A_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exp_csr("estat_wmask", A_ESTAT, 32'h3);
        exp_out("has_int_swi", SEL_HAS_INT, 32'h1);
        drain();
        csr_write(A_ESTAT, 32'h3, 32'h0);
        csr_write(A_ECFG, 32'hFFFF_FFFF, 32'h0);
        exp_csr("estat_clr", A_ESTAT, 32'h0);
        exp_csr("ecfg_clr", A_ECFG, 32'h0);
        drain();

        csr_write(A_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exp_csr("unimpl_rd", A_NONE, 32'h0);
        drain();

        csr_write(A_SAVE2, 32'hFFFF_0000, 32'hA5A5_5A5A);
        exp_csr("save2_hi", A_SAVE2, 32'hA5A5_0000);
        drain();
        csr_write(A_SAVE2, 32'h00FF_00FF, 32'h0000_FFFF);
        exp_csr("save2_mix", A_SAVE2, 32'hA500_00FF);
        exp_csr("save1_untouched", A_SAVE1, 32'h0);
        drain();

        // Exception and return
        csr_write(A_CRMD, 32'h7, 32'h7);
        exp_csr("crmd_setup", A_CRMD, 32'hF);
        drain();
        pulse_ex(6'hB, 9'h0, 32'h1C00_0100);
        tick();
        wb_ex = 1'b0;
        exp_csr("ex_crmd", A_CRMD, 32'h8);
        exp_csr("ex_prmd", A_PRMD, 32'h7);
        exp_csr("ex_era", A_ERA, 32'h1C00_0100);
        exp_csr("ex_estat", A_ESTAT, 32'h000B_0000);
        exp_out("ex_ertn_pc", SEL_ERTN_PC, 32'h1C00_0100);
        drain();
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        exp_csr("ertn_crmd", A_CRMD, 32'hF);
        drain();

        // Exception beats a same-cycle CRMD write
        pulse_ex(6'hB, 9'h0, 32'h1C00_0200);
        csr_write(A_CRMD, 32'h7, 32'h3);
        wb_ex = 1'b0;
        exp_csr("exwr_crmd", A_CRMD, 32'h8);
        exp_csr("exwr_prmd", A_PRMD, 32'h7);
        exp_csr("exwr_era", A_ERA, 32'h1C00_0200);
        drain();

        // Exception beats a same-cycle ertn
        csr_write(A_PRMD, 32'h7, 32'h5);
        csr_write(A_CRMD, 32'h7, 32'h6);
        exp_csr("prmd_set", A_PRMD, 32'h5);
        exp_csr("crmd_set", A_CRMD, 32'hE);
        drain();
        pulse_ex(6'h08, 9'h1FF, 32'h1C00_0300);
        ertn_flush = 1'b1;
        tick();
        wb_ex = 1'b0; ertn_flush = 1'b0;
        exp_csr("exertn_crmd", A_CRMD, 32'h8);
        exp_csr("exertn_prmd", A_PRMD, 32'h6);
        exp_csr("exertn_estat", A_ESTAT, 32'h7FC8_0000);
        drain();

        // ertn beats a same-cycle CRMD write
        ertn_flush = 1'b1;
        csr_write(A_CRMD, 32'h7, 32'h1);
        ertn_flush = 1'b0;
        exp_csr("ertnwr_crmd", A_CRMD, 32'hE);
        drain();

        // One-shot timer: InitVal=4, En=1
        csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h11);
        exp_csr("tcfg_rd", A_TCFG, 32'h11);
        exp_csr("tval_load", A_TVAL, 32'd16);
        drain();
        for (int i = 15; i >= 0; i--) begin
            tick();
            exp_csr($sformatf("tval_cnt%0d", i), A_TVAL, 32'(i));
            drain();
        end
        exp_csr("is11_not_yet", A_ESTAT, 32'h7FC8_0000);
        drain();
        tick();
        exp_csr("is11_set", A_ESTAT, 32'h7FC8_0800);
        exp_csr("tval_expired", A_TVAL, 32'hFFFF_FFFF);
        exp_out("has_int_masked", SEL_HAS_INT, 32'h0);
        drain();
        tick();
        exp_csr("tval_hold", A_TVAL, 32'hFFFF_FFFF);
        drain();
        csr_write(A_ECFG, 32'hFFFF_FFFF, 32'h800);
        exp_out("has_int_timer", SEL_HAS_INT, 32'h1);
        drain();

        // TICLR
        csr_write(A_TICLR, 32'h1, 32'h0);
        exp_csr("ticlr_noop", A_ESTAT, 32'h7FC8_0800);
        drain();
        csr_write(A_TICLR, 32'h1, 32'h1);
        exp_csr("ticlr_clr", A_ESTAT, 32'h7FC8_0000);
        exp_out("has_int_cleared", SEL_HAS_INT, 32'h0);
        drain();

        // Periodic timer: InitVal=1, Periodic=1, En=1
        csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h7);
        exp_csr("per_load", A_TVAL, 32'd4);
        drain();
        for (int i = 3; i >= 0; i--) begin
            tick();
            exp_csr($sformatf("per_cnt%0d", i), A_TVAL, 32'(i));
            drain();
        end
        exp_csr("per_is11_clear", A_ESTAT, 32'h7FC8_0000);
        drain();
        tick();
        exp_csr("per_fire1", A_ESTAT, 32'h7FC8_0800);
        exp_csr("per_reload", A_TVAL, 32'd4);
        drain();
        csr_write(A_TICLR, 32'h1, 32'h1);
        exp_csr("per_clr", A_ESTAT, 32'h7FC8_0000);
        exp_csr("per_cnt3b", A_TVAL, 32'd3);
        drain();
        tick(); tick(); tick();
        exp_csr("per_cnt0b", A_TVAL, 32'd0);
        exp_csr("per_still_clr", A_ESTAT, 32'h7FC8_0000);
        drain();
        csr_write(A_TICLR, 32'h1, 32'h1);
        exp_csr("per_set_wins", A_ESTAT, 32'h7FC8_0800);
        exp_csr("per_reload2", A_TVAL, 32'd4);
        drain();

        // En=0 freezes TVAL
        csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h9);
        exp_csr("frz_load", A_TVAL, 32'd8);
        drain();
        csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h8);
        exp_csr("frz_tcfg", A_TCFG, 32'h8);
        exp_csr("frz_now", A_TVAL, 32'd8);
        drain();
        tick(); tick();
        exp_csr("frz_hold", A_TVAL, 32'd8);
        drain();

        // Interrupt sampling latency and IE gating
        csr_write(A_ECFG, 32'hFFFF_FFFF, 32'h4);
        hw_int_in = 8'h01;
        exp_out("hw_latency", SEL_HAS_INT, 32'h0);
        drain();
        tick();
        exp_out("hw_has_int", SEL_HAS_INT, 32'h1);
        exp_csr("hw_estat", A_ESTAT, 32'h7FC8_0804);
        drain();
        csr_write(A_CRMD, 32'h4, 32'h0);
        exp_csr("ie_off_crmd", A_CRMD, 32'hA);
        exp_out("ie_off_has_int", SEL_HAS_INT, 32'h0);
        drain();
        csr_write(A_CRMD, 32'h4, 32'h4);
        hw_int_in = 8'h00; ipi_int_in = 1'b1;
        csr_write(A_ECFG, 32'hFFFF_FFFF, 32'h1000);
        exp_csr("ipi_estat", A_ESTAT, 32'h7FC8_1800);
        exp_out("ipi_has_int", SEL_HAS_INT, 32'h1);
        drain();
        ipi_int_in = 1'b0;

        // Reset overrides running timer, exception and write
        csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h41);
        tick();
        resetn = 1'b0; hw_int_in = 8'hFF;
        pulse_ex(6'h3, 9'h3, 32'hDEAD_BEE0);
        csr_write(A_CRMD, 32'h7, 32'h7);
        wb_ex = 1'b0;
        exp_csr("rst2_crmd", A_CRMD, 32'h8);
        exp_csr("rst2_prmd", A_PRMD, 32'h0);
        exp_csr("rst2_era", A_ERA, 32'h0);
        exp_csr("rst2_estat", A_ESTAT, 32'h0);
        exp_csr("rst2_tcfg", A_TCFG, 32'h0);
        exp_csr("rst2_tval", A_TVAL, 32'hFFFF_FFFF);
        exp_csr("rst2_save2", A_SAVE2, 32'h0);
        exp_out("rst2_ex_entry", SEL_EX_ENTRY, 32'h0);
        exp_out("rst2_has_int", SEL_HAS_INT, 32'h0);
        drain();
        resetn = 1'b1;
        tick();
        exp_csr("post_rst_hw", A_ESTAT, 32'h0000_03FC);
        exp_csr("post_rst_tval", A_TVAL, 32'hFFFF_FFFF);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_regfile.md
# csr_regfile

Architectural control/status register file for the LoongArch pipeline. It is the responder end of the writeback stage's CSR interface. It accepts masked CSR writes, exception commits and `ertn` flushes from WB, and serves combinational CSR reads to ID/EXE. It also supplies the exception entry and return PCs, and runs the stable-counter timer that raises the timer interrupt.

## Interface
- No parameters.
- `clk` input 1: clock.
- `resetn` input 1: reset, synchronous, active-low.
- `csr_num` input 14: read address.
- `csr_rvalue` output 32: read data for `csr_num`.
- `csr_we` input 1: write strobe, already qualified by WB valid.
- `csr_wr_num` input 14: write address.
- `csr_wr_mask` input 32: bit-enable for the write.
- `csr_wr_value` input 32: write data.
- `wb_ex` input 1: exception committing in WB this cycle.
- `wb_ecode` input 6: exception code.
- `wb_esubcode` input 9: exception subcode.
- `wb_pc` input 32: PC of the excepting instruction.
- `ertn_flush` input 1: `ertn` committing in WB.
- `hw_int_in` input 8: external interrupt lines.
- `ipi_int_in` input 1: inter-processor interrupt.
- `ex_entry` output 32: EENTRY value, used as the redirect target.
- `ertn_pc` output 32: ERA value.
- `has_int` output 1: interrupt pending and enabled.

## Operation
- Implemented registers (address: fields, reset value, writable mask):
  - CRMD 0x0: PLV[1:0], IE[2], DA[3]=1 fixed. Reset 0x00000008. Writable 0x7.
  - PRMD 0x1: PPLV[1:0], PIE[2]. Reset 0. Writable 0x7.
  - ECFG 0x4: LIE[12:0], bit 10 reserved. Reset 0. Writable 0x1BFF.
  - ESTAT 0x5: IS[12:0], Ecode[21:16], EsubCode[30:22]. Reset 0. Software-writable only IS[1:0] (mask 0x3).
  - ERA 0x6: full 32 bits. Reset 0.
  - EENTRY 0xC: VA[31:6]; bits [5:0] always read 0. Reset 0.
  - SAVE0–3 0x30–0x33: full 32 bits. Reset 0.
  - TID 0x40: full 32 bits. Reset 0.
  - TCFG 0x41: En[0], Periodic[1], InitVal[31:2]. Reset 0.
  - TVAL 0x42: read-only. Reset 0xFFFFFFFF.
  - TICLR 0x44: write-only; reads 0.
- Masked write rule: `new = (old & ~(mask & W)) | (value & mask & W)`, where `W` is the register's writable mask.
- Unimplemented addresses read 0. Writes to them are ignored.
- Exception commit (`wb_ex`=1):
  - PRMD.PPLV←CRMD.PLV and PRMD.PIE←CRMD.IE.
  - CRMD.PLV←0 and CRMD.IE←0.
  - ERA←`wb_pc`.
  - ESTAT.Ecode←`wb_ecode` and ESTAT.EsubCode←`wb_esubcode`.
- `ertn_flush`=1: CRMD.PLV←PRMD.PPLV and CRMD.IE←PRMD.PIE.
- Priority on the same field in the same cycle: `wb_ex` > `ertn_flush` > `csr_we`.
- Interrupt status:
  - ESTAT.IS[9:2]←`hw_int_in` every cycle.
  - ESTAT.IS[12]←`ipi_int_in` every cycle.
  - IS[11] is the timer-pending bit. It is set by the timer and cleared only through TICLR.
- `has_int` = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).
- Timer, evaluated each cycle in priority order:
  1. TCFG write with resulting En=1: TVAL←{new InitVal, 2'b00}.
  2. Otherwise, if En=1 and TVAL=0: IS[11]←1, and TVAL←(Periodic ? {InitVal,2'b00} : 0xFFFFFFFF).
  3. Otherwise, if En=1 and TVAL≠0xFFFFFFFF: TVAL←TVAL−1.
  4. TVAL=0xFFFFFFFF with En=1 is one-shot expired and holds.
  5. En=0 freezes TVAL.
- TICLR write with (mask&value)[0]=1 clears IS[11]. A timer set in the same cycle wins, so IS[11] stays 1.
- `ex_entry`={EENTRY.VA,6'b0}; `ertn_pc`=ERA.

## Timing
- `csr_rvalue`, `ex_entry`, `ertn_pc` and `has_int` are combinational from register state.
- Writes, exception and `ertn` updates take effect at the next posedge. There is no write-to-read bypass: a read of the same CSR in the write cycle returns the old value.
- `hw_int_in` and `ipi_int_in` reach IS, and hence `has_int`, with 1 cycle latency.
- Reset is synchronous. Every register takes its listed reset value; outputs then read CRMD=0x8, `has_int`=0, `ex_entry`=0, `ertn_pc`=0, TVAL=0xFFFFFFFF.
- Reset asserted during timer countdown or an exception commit overrides all updates.

## Test plan
- Masked write: write CRMD with value 0xFFFFFFFF, mask 0x4. Next cycle CRMD reads 0xC. Then write EENTRY 0x1234567F with full mask; it reads 0x12345640.
- Exception and return:
  - Setup: CRMD=0x7 (PLV3, IE=1).
  - Stimulus: pulse `wb_ex` with ecode 0xB, esubcode 0, pc 0x1C000100.
  - Required: CRMD=0x8, PRMD=0x7, ERA=0x1C000100, ESTAT[21:16]=0xB.
  - Then pulse `ertn_flush`: CRMD=0xF.
- Simultaneous events:
  - `wb_ex` together with a CRMD write of 0x3 → CRMD=0x8.
  - `wb_ex` together with `ertn_flush` → exception result.
- One-shot timer: TCFG write 0x00000011 (InitVal=4, En=1). TVAL counts 16→0 over 16 cycles. IS[11] sets the next cycle, TVAL then holds 0xFFFFFFFF, and `has_int` rises once ECFG.LIE[11]=1 and IE=1.
- Timer clear: TICLR write of 1 clears IS[11]. With Periodic=1 and InitVal=1, IS[11] re-sets every 5 cycles. A clear coinciding with a set leaves IS[11]=1.
- Interrupt sampling: `hw_int_in`=0x01 with LIE[2]=1 and IE=1 → `has_int`=1 one cycle later. With IE=0, `has_int`=0.
